// File: rtl/rvv_skid_buf.sv
// Two-entry skid buffer for a valid/ready stream.
// Every output is driven straight from a flop, so the upstream and downstream
// handshakes never have a combinational path between them.
// The main entry feeds out_data. The skid entry catches the one beat that
// arrives during the cycle the downstream starts stalling.
module rvv_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  // Handshakes use the registered ready/valid, so the fires depend only on flops and inputs.
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

  // Next state and data-load enables. Flush overrides every transition and write.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_next   = S_BUSY;
          w_load_main_in = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_next = S_FULL;
          w_load_skid  = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the downstream side can move.
        if (w_out_fire) begin
          w_state_next     = S_BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_next     = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // State register. Handshake flags are precomputed from the next state so that each is a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next != S_EMPTY);
      r_in_ready  <= (w_state_next != S_FULL);
    end
  end

  // Payload registers change only when their entry is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_rvv_skid_buf.sv
// Self-checking bench for rvv_skid_buf with WIDTH=8.
// The reference model is a FIFO queue with capacity 2:
// - ready means there is room in the queue.
// - valid means the queue is not empty.
// - out_data is the head of the queue.
module tb_rvv_skid_buf;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];

  rvv_skid_buf #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model across the edge, then compare.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic m_in_fire;
    logic m_out_fire;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    m_in_fire  = iv && (q.size() < 2);
    m_out_fire = ordy && (q.size() > 0);
    @(posedge clk);
    if (m_out_fire) begin
      $display("[TB] out beat %02h", q[0]);
      void'(q.pop_front());
    end
    if (fl) q.delete();
    else if (m_in_fire) q.push_back(id);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) check("out_data", {24'd0, out_data}, {24'd0, q[0]});
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset values must appear before any clock edge.
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", {24'd0, out_data}, 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with out_ready held high.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check("stream_data", {24'd0, out_data}, i);
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill both entries, then hold a third beat upstream.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head", {24'd0, out_data}, 32'hA1);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    check("bp_hold_data", {24'd0, out_data}, 32'hA1);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    check("bp_second", {24'd0, out_data}, 32'hA2);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    check("bp_third", {24'd0, out_data}, 32'hA3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Simultaneous accept and consume while one beat is held.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    check("sim_data", {24'd0, out_data}, 32'h66);
    check("sim_valid", {31'd0, out_valid}, 32'd1);
    check("sim_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush while full, with both handshakes active.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_quiet", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a cycle while full.
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h45, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    check("arst_after_data", {24'd0, out_data}, 32'h7E);
    check("arst_after_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic compared against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
